// File: rtl/nes_irq_controller.sv
// ---------------------------------------------------------------------------
// nes_irq_controller
//
// Interrupt front end for the NES CPU core. Collects NUM_SRC maskable IRQ
// sources (each level- or rising-edge-sensitive), an edge-latched NMI and the
// post-reset request. At each instruction-boundary poll it decides whether
// the CPU must run the interrupt sequence and of which kind. During the
// following vector fetch it supplies the vector address.
//
// Handshake: the CPU sequencer owns the timing. A poll in IDLE commits a
// decision (take/kind/src_id, visible the next cycle). The decision is then
// held until the CPU has done the low-byte fetch (vec_rd & !vec_hi) followed
// by the high-byte fetch (vec_rd & vec_hi). Polls in between are ignored.
//
// Ports:
//   clk, reset   - clock; synchronous active-low reset
//   ce           - clock enable; all state holds when 0 (reset still acts)
//   irq_src      - raw IRQ lines, active-high
//   irq_en       - per-source enable mask
//   i_flag       - CPU I flag; 1 masks every IRQ
//   nmi          - NMI line, rising-edge sensitive
//   poll         - CPU interrupt-sample cycle
//   vec_rd       - CPU vector fetch this cycle
//   vec_hi       - with vec_rd: 1 = high byte, 0 = low byte
//   src_clr      - clears latched edge-pending bits
//   take         - registered: run the interrupt sequence
//   kind         - registered: 0 none/BRK, 1 IRQ, 2 NMI, 3 reset
//   src_id       - registered: winning IRQ source
//   vec_addr     - combinational vector address
//   pending      - registered per-source pending status
//   nmi_pend     - registered NMI latch
//   fsm_state    - debug: 0 IDLE, 1 ARMED, 2 FETCH
// ---------------------------------------------------------------------------
module nes_irq_controller #(
    parameter int                 NUM_SRC   = 4,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = '0,
    parameter bit                 VECTORED  = 1'b0,
    parameter logic [15:0]        VEC_BASE  = 16'hFFE0,
    localparam int                SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_en,
    input  logic               i_flag,
    input  logic               nmi,
    input  logic               poll,
    input  logic               vec_rd,
    input  logic               vec_hi,
    input  logic [NUM_SRC-1:0] src_clr,
    output logic               take,
    output logic [1:0]         kind,
    output logic [SRC_W-1:0]   src_id,
    output logic [15:0]        vec_addr,
    output logic [NUM_SRC-1:0] pending,
    output logic               nmi_pend,
    output logic [1:0]         fsm_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FETCH = 2'd2
    } state_t;

    localparam logic [1:0] KIND_NONE  = 2'd0;
    localparam logic [1:0] KIND_IRQ   = 2'd1;
    localparam logic [1:0] KIND_NMI   = 2'd2;
    localparam logic [1:0] KIND_RESET = 2'd3;

    state_t             state_q;
    state_t             state_d;
    logic               take_q,   take_d;
    logic [1:0]         kind_q,   kind_d;
    logic [SRC_W-1:0]   src_q,    src_d;
    logic [NUM_SRC-1:0] pend_q,   pend_d;
    logic [NUM_SRC-1:0] prev_q;
    logic               nmi_last_q;
    logic               nmi_pend_q, nmi_pend_d;

    logic               lo_fetch;
    logic               hi_fetch;
    logic               nmi_block;
    logic               nmi_edge;
    logic               want_nmi;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] irq_ack;
    logic [SRC_W-1:0]   win_id;
    logic [14:0]        vec_word;

    assign lo_fetch = vec_rd & ~vec_hi;
    assign hi_fetch = vec_rd &  vec_hi;

    // NMI capture is frozen while a vector fetch is under way and during the
    // whole reset sequence. nmi_last holds too, so a line that went high in
    // that window is seen as an edge on the first unblocked cycle.
    assign nmi_block  = (state_q == ST_FETCH) ||
                        ((kind_q == KIND_RESET) && (state_q != ST_IDLE));
    assign nmi_edge   = ~nmi_block & nmi & ~nmi_last_q;
    assign want_nmi   = nmi_pend_q | nmi_edge;
    // A fresh edge wins over the acknowledge in the same cycle.
    assign nmi_pend_d = nmi_edge |
                        (nmi_pend_q & ~(lo_fetch & (kind_q == KIND_NMI)));

    assign eligible = pend_q & irq_en & {NUM_SRC{~i_flag}};

    // Lowest-index eligible source wins.
    always_comb begin
        win_id = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                win_id = SRC_W'(k);
            end
        end
    end

    // Edge latches: set beats clear; cleared by src_clr or by the low-byte
    // fetch of the IRQ that this source won. Level sources just register.
    always_comb begin
        irq_ack = '0;
        pend_d  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            irq_ack[k] = lo_fetch && (kind_q == KIND_IRQ) && (src_q == SRC_W'(k));
            if (EDGE_MASK[k]) begin
                pend_d[k] = (irq_src[k] & ~prev_q[k]) |
                            (pend_q[k] & ~(src_clr[k] | irq_ack[k]));
            end else begin
                pend_d[k] = irq_src[k];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_ARMED;
        end else if (ce) begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (poll && (want_nmi || (|eligible))) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (lo_fetch) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (hi_fetch) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output (decision) logic: next values of take/kind/src_id
    always_comb begin
        take_d = take_q;
        kind_d = kind_q;
        src_d  = src_q;
        case (state_q)
            ST_IDLE: begin
                if (poll) begin
                    if (want_nmi) begin
                        take_d = 1'b1;
                        kind_d = KIND_NMI;
                        src_d  = '0;
                    end else if (|eligible) begin
                        take_d = 1'b1;
                        kind_d = KIND_IRQ;
                        src_d  = win_id;
                    end else begin
                        take_d = 1'b0;
                        kind_d = KIND_NONE;
                    end
                end
            end
            ST_FETCH: begin
                if (hi_fetch) begin
                    take_d = 1'b0;
                    kind_d = KIND_NONE;
                end
            end
            default: ;
        endcase
    end

    // Decision and source registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            take_q     <= 1'b1;
            kind_q     <= KIND_RESET;
            src_q      <= '0;
            pend_q     <= '0;
            prev_q     <= '0;
            nmi_last_q <= 1'b0;
            nmi_pend_q <= 1'b0;
        end else if (ce) begin
            take_q     <= take_d;
            kind_q     <= kind_d;
            src_q      <= src_d;
            pend_q     <= pend_d;
            prev_q     <= irq_src;
            nmi_pend_q <= nmi_pend_d;
            if (!nmi_block) begin
                nmi_last_q <= nmi;
            end
        end
    end

    // Vector address, kept as a word address (bit0 comes from vec_hi).
    always_comb begin
        case (kind_q)
            KIND_RESET: vec_word = 15'h7FFE;
            KIND_NMI:   vec_word = 15'h7FFD;
            KIND_IRQ: begin
                if (VECTORED) begin
                    vec_word = VEC_BASE[15:1] + {{(15 - SRC_W){1'b0}}, src_q};
                end else begin
                    vec_word = 15'h7FFF;
                end
            end
            default:    vec_word = 15'h7FFF;
        endcase
    end

    assign vec_addr  = {vec_word, vec_hi};
    assign take      = take_q;
    assign kind      = kind_q;
    assign src_id    = src_q;
    assign pending   = pend_q;
    assign nmi_pend  = nmi_pend_q;
    assign fsm_state = state_q;

endmodule
